// File: rtl/sequential_divider_16bit_pkg.sv
// rtl/sequential_divider_16bit_pkg.sv - shared width, FSM encodings and divide-by-zero constants
package sequential_divider_16bit_pkg;

   localparam int DIV_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIVIDE = 2'd1,
      ST_DONE   = 2'd2
   } div_state_t;

   localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/sequential_divider_16bit_cla_sub.sv
// rtl/sequential_divider_16bit_cla_sub.sv - carry-lookahead adder wired as a - b (b inverted, carry-in 1)
module carry_lookahead_subtractor #(
   parameter int N = 17
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow_n
);

   logic [N-1:0] b_inv;
   logic [N-1:0] gen;
   logic [N-1:0] prop;
   logic [N:0]   carry;
   logic         term;
   logic         span;

   assign b_inv = ~b;
   assign gen   = a & b_inv;
   assign prop  = a ^ b_inv;

   // Each carry is the flat lookahead sum of generates, not a ripple chain.
   always_comb begin
      carry    = '0;
      term     = 1'b0;
      span     = 1'b0;
      carry[0] = 1'b1;
      for (int i = 0; i < N; i++) begin
         term = gen[i];
         span = prop[i];
         for (int j = i - 1; j >= 0; j--) begin
            term = term | (span & gen[j]);
            span = span & prop[j];
         end
         carry[i+1] = term | span;
      end
   end

   assign diff     = prop ^ carry[N-1:0];
   assign borrow_n = carry[N];

endmodule

// File: rtl/sequential_divider_16bit.sv
// rtl/sequential_divider_16bit.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
module sequential_divider_16bit
   import sequential_divider_16bit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   div_state_t       state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] part_rem;
   logic [WIDTH-1:0] quo_sh;
   logic [WIDTH-1:0] divisor_r;

   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             borrow_n;
   logic [WIDTH-1:0] part_rem_next;
   logic [WIDTH-1:0] quo_next;

   assign trial = {part_rem, quo_sh[WIDTH-1]};

   carry_lookahead_subtractor #(.N(WIDTH + 1)) u_sub (
      .a        (trial),
      .b        ({1'b0, divisor_r}),
      .diff     (diff),
      .borrow_n (borrow_n)
   );

   // Partial remainder stays below the divisor, so diff's sign bit and the carry-out agree.
   assign part_rem_next = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quo_next      = {quo_sh[WIDTH-2:0], borrow_n};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         count       <= '0;
         part_rem    <= '0;
         quo_sh      <= '0;
         divisor_r   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
               if (start) begin
                  if (divisor == '0) begin
                     state       <= ST_DONE;
                     done        <= 1'b1;
                     quotient    <= {WIDTH{1'b1}};
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state     <= ST_DIVIDE;
                     busy      <= 1'b1;
                     divisor_r <= divisor;
                     part_rem  <= '0;
                     quo_sh    <= dividend;
                     count     <= CW'(WIDTH - 1);
                  end
               end
            end
            ST_DIVIDE: begin
               part_rem <= part_rem_next;
               quo_sh   <= quo_next;
               if (count == '0) begin
                  state       <= ST_DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  quotient    <= quo_next;
                  remainder   <= part_rem_next;
                  div_by_zero <= 1'b0;
               end else begin
                  count <= count - 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
